// File: rtl/serial_adder_fsm_if.sv
// Valid/ready bundle between an operand producer, the bit-serial adder and the
// result consumer.
interface serial_adder_fsm_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  cout,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output cout,
        output busy
    );

endinterface

// File: rtl/serial_adder_fsm.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, carry held in a
// register between bits; result returned through a valid/ready handshake.
module serial_adder_fsm #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_adder_fsm_if.slave   bus
);

    localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             load_c;
    logic             step_c;
    logic             last_c;
    logic             drain_c;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             busy_q;

    logic             fa_s_c;
    logic             fa_co_c;

    // fulladderTP cell: the only arithmetic in the block
    always_comb begin : fulladder_tp
        fa_s_c  = sa[0] ^ sb[0] ^ carry;
        fa_co_c = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        step_c    = 1'b0;
        last_c    = 1'b0;
        drain_c   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    load_c    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                step_c = 1'b1;
                if (cnt == LAST) begin
                    last_c    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    drain_c   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // sa doubles as the sum shift register: its vacated top bit collects s
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (load_c) begin
            sa    <= bus.a;
            sb    <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
        end else if (step_c) begin
            sa    <= {fa_s_c, sa[WIDTH-1:1]};
            sb    <= {1'b0, sb[WIDTH-1:1]};
            carry <= fa_co_c;
            cnt   <= cnt + CW'(1);
            if (last_c) begin
                sum_q  <= {fa_s_c, sa[WIDTH-1:1]};
                cout_q <= fa_co_c;
            end
        end
    end

    // Handshake flags registered from the next state so they track state exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            if (last_c) begin
                out_valid_q <= 1'b1;
            end else if (drain_c) begin
                out_valid_q <= 1'b0;
            end
            in_ready_q <= (state_nxt == IDLE);
            busy_q     <= (state_nxt == SHIFT);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Directed-vector and scoreboarded random bench for serial_adder_fsm (WIDTH=32).
module tb_serial_adder_fsm;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NRAND  = 1000;
    localparam int unsigned NVEC   = 9;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        string       name;
    } vec_t;

    logic clk;
    logic rst_n;
    logic clk_en;

    int n_vec;
    int n_fail;

    vec_t vecs [NVEC];
    logic [32:0] exp_q [$];

    serial_adder_fsm_if #(.WIDTH(WIDTH)) bus ();

    serial_adder_fsm #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for a negedge with in_ready high; returns 0 on timeout.
    task automatic wait_ready(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({name, " in_ready timeout"}, 64'd0, 64'd1);
    endtask

    // Count posedges until out_valid is seen (#1 after the edge); 0 on timeout.
    task automatic wait_result(output int lat);
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_add(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic [31:0] esum, input logic ecout, input string name);
        bit ok;
        int lat;
        wait_ready(name, ok);
        if (ok) begin
            bus.a        = a;
            bus.b        = b;
            bus.cin      = cin;
            bus.in_valid = 1'b1;
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            wait_result(lat);
            check({name, " latency"}, 64'(lat), 64'd32);
            check({name, " sum"}, 64'(bus.sum), 64'(esum));
            check({name, " cout"}, 64'(bus.cout), 64'(ecout));
            @(posedge clk);
            #1;
            check({name, " out_valid drop"}, 64'(bus.out_valid), 64'd0);
        end
    endtask

    initial begin
        bit ok;
        int lat;
        int cyc;
        int acc_cyc [2];
        int n_acc;
        int issued;
        int recv;
        bit saw_valid;
        logic [32:0] e;

        n_vec  = 0;
        n_fail = 0;

        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, "all_ones_plus_one"};
        vecs[1] = '{32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0, "mixed_cin"};
        vecs[2] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, "zero"};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, "max_all"};
        vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, "msb_carry"};
        vecs[5] = '{32'h00000003, 32'h00000004, 1'b0, 32'h00000007, 1'b0, "small"};
        vecs[6] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0, "cin_ripple"};
        vecs[7] = '{32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hFFFFFFFF, 1'b0, "alt_no_cin"};
        vecs[8] = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1, "alt_cin"};

        // Reset with the clock stopped
        clk_en        = 1'b0;
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check("rst out_valid", 64'(bus.out_valid), 64'd0);
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst sum", 64'(bus.sum), 64'd0);
        check("rst cout", 64'(bus.cout), 64'd0);
        check("rst in_ready", 64'(bus.in_ready), 64'd1);

        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post-rst out_valid", 64'(bus.out_valid), 64'd0);
        check("post-rst busy", 64'(bus.busy), 64'd0);
        check("post-rst sum", 64'(bus.sum), 64'd0);
        check("post-rst in_ready", 64'(bus.in_ready), 64'd1);

        for (int i = 0; i < int'(NVEC); i++) begin
            do_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].name);
        end

        // Backpressure with new operands held valid throughout
        bus.out_ready = 1'b0;
        wait_ready("bp", ok);
        bus.a = 32'h11111111; bus.b = 32'h22222222; bus.cin = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.a = 32'h0F0F0F0F; bus.b = 32'hF0F0F0F0; bus.cin = 1'b1;
        wait_result(lat);
        check("bp latency", 64'(lat), 64'd32);
        for (int i = 0; i < 5; i++) begin
            check("bp hold out_valid", 64'(bus.out_valid), 64'd1);
            check("bp hold sum", 64'(bus.sum), 64'h33333333);
            check("bp hold cout", 64'(bus.cout), 64'd0);
            check("bp hold in_ready", 64'(bus.in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp after hs in_ready", 64'(bus.in_ready), 64'd1);
        check("bp after hs out_valid", 64'(bus.out_valid), 64'd0);
        check("bp after hs busy", 64'(bus.busy), 64'd0);
        check("bp after hs sum kept", 64'(bus.sum), 64'h33333333);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp second accept busy", 64'(bus.busy), 64'd1);
        check("bp second accept in_ready", 64'(bus.in_ready), 64'd0);
        wait_result(lat);
        check("bp second latency", 64'(lat), 64'd32);
        check("bp second sum", 64'(bus.sum), 64'h00000000);
        check("bp second cout", 64'(bus.cout), 64'd1);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of SHIFT
        wait_ready("midrst", ok);
        bus.a = 32'hDEADBEEF; bus.b = 32'h01234567; bus.cin = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst busy", 64'(bus.busy), 64'd0);
        check("midrst in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst sum", 64'(bus.sum), 64'd0);
        check("midrst cout", 64'(bus.cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) saw_valid = 1'b1;
        end
        check("midrst no result", 64'(saw_valid), 64'd0);
        do_add(32'h00000003, 32'h00000004, 1'b0, 32'h00000007, 1'b0, "after_midrst");

        // Initiation interval with both handshakes held high
        wait_ready("ii", ok);
        bus.a = 32'h01020304; bus.b = 32'h10203040; bus.cin = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 2 && cyc < 200) begin
            if (bus.in_ready) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            if (n_acc < 2) begin
                @(negedge clk);
                cyc++;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("ii accepts", 64'(n_acc), 64'd2);
        if (n_acc == 2) check("ii cycles", 64'(acc_cyc[1] - acc_cyc[0]), 64'd34);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready && !bus.out_valid) break;
        end
        check("ii drain idle", 64'(bus.in_ready && !bus.out_valid), 64'd1);

        // Random traffic against an in-order scoreboard
        issued = 0;
        recv   = 0;
        cyc    = 0;
        while (recv < int'(NRAND) && cyc < 80000) begin
            @(negedge clk);
            cyc++;
            bus.a         = $urandom;
            bus.b         = $urandom;
            bus.cin       = 1'($urandom_range(0, 1));
            bus.in_valid  = (issued < int'(NRAND)) && ($urandom_range(0, 3) != 0);
            bus.out_ready = 1'($urandom_range(0, 1));
            if (bus.in_valid && bus.in_ready) begin
                e = 33'(bus.a) + 33'(bus.b) + 33'(bus.cin);
                exp_q.push_back(e);
                issued++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("random unexpected result", 64'({bus.cout, bus.sum}), 64'h1_0000_0000_0000);
                end else begin
                    e = exp_q.pop_front();
                    check("random result", 64'({bus.cout, bus.sum}), 64'(e));
                end
                recv++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("random received count", 64'(recv), 64'(NRAND));
        check("random issued count", 64'(issued), 64'(NRAND));
        check("random leftover", 64'(exp_q.size()), 64'd0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
